// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM: decodes Op and sequences the shared datapath with mem_ready stalls.
// Optional addi support is enabled by defining MAIN_CTRL_ADDI_EN.
module mips_main_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    Op,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               instr_done,
    output logic               illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_MEMWB  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
`ifdef MAIN_CTRL_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
`ifdef MAIN_CTRL_ADDI_EN
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
`endif

    state_t state, state_nx;

    logic ir_w, pc_w, br, mem_w, reg_w, done, ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = S_FETCH;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        br       = 1'b0;
        mem_w    = 1'b0;
        reg_w    = 1'b0;
        done     = 1'b0;
        ill      = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = '0;
        PCSrc    = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                ir_w     = mem_ready;
                pc_w     = mem_ready;
                state_nx = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXEC;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_J:         state_nx = S_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_nx = S_ADDIEX;
`endif
                    default: begin
                        ill      = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                state_nx = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD     = 1'b1;
                state_nx = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                mem_w    = mem_ready;
                done     = mem_ready;
                state_nx = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                reg_w    = 1'b1;
                MemtoReg = 1'b1;
                done     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_W'(2'b10);
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w  = 1'b1;
                RegDst = 1'b1;
                done   = 1'b1;
            end
`ifdef MAIN_CTRL_ADDI_EN
            S_ADDIEX: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                state_nx = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_w = 1'b1;
                done  = 1'b1;
            end
`endif
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_W'(2'b01);
                PCSrc   = 2'b01;
                br      = 1'b1;
                done    = 1'b1;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                pc_w  = 1'b1;
                done  = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n so nothing fires while reset is held, even in FETCH with mem_ready high.
    assign IRWrite    = ir_w  & rst_n;
    assign PCEn       = (pc_w | (br & Zero)) & rst_n;
    assign MemWrite   = mem_w & rst_n;
    assign RegWrite   = reg_w & rst_n;
    assign instr_done = done  & rst_n;
    assign illegal_op = ill   & rst_n;

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Self-checking bench for mips_main_ctrl: per-cycle vector table plus hand-written reset and stall sequences.
module tb_mips_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, instr_done, illegal_op;

    int tests = 0;
    int fails = 0;

    mips_main_ctrl #(.OP_W(6), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .instr_done(instr_done),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Packed order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp PCSrc PCEn instr_done illegal_op
    function automatic logic [15:0] e(input logic iord, input logic mw, input logic irw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                      input logic [1:0] pcs, input logic pce, input logic dn,
                                      input logic il);
        return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pce, dn, il};
    endfunction

    function automatic logic [15:0] actual();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
                ALUOp, PCSrc, PCEn, instr_done, illegal_op};
    endfunction

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                       input logic [15:0] exp);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    logic [15:0] RST, F1, F0, DEC, DILL, MA, MRD, MWR0, MWR1, MWB, EXE, AWB, BRZ1, BRZ0, JMP;
`ifdef MAIN_CTRL_ADDI_EN
    logic [15:0] IWB;
`endif

    initial begin
        int lat;
        RST  = e(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
        F1   = e(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
        F0   = RST;
        DEC  = e(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
        DILL = e(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,1);
        MA   = e(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
        MRD  = e(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
        MWR0 = MRD;
        MWR1 = e(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0);
        MWB  = e(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,1,0);
        EXE  = e(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
        AWB  = e(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,1,0);
        BRZ1 = e(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,1,0);
        BRZ0 = e(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1,0);
        JMP  = e(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,1,0);
`ifdef MAIN_CTRL_ADDI_EN
        IWB  = e(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0);
`endif

        // reset with mem_ready high, then first FETCH
        add(0, 6'h00, 0, 1, RST);  add(0, 6'h00, 0, 1, RST);
        // R-type, Zero high must not leak into PCEn
        add(1, 6'h00, 1, 1, F1);   add(1, 6'h00, 1, 1, DEC);
        add(1, 6'h00, 1, 1, EXE);  add(1, 6'h00, 1, 1, AWB);
        // lw with a FETCH stall and 3 MEMRD stalls
        add(1, 6'h23, 0, 0, F0);   add(1, 6'h23, 0, 1, F1);
        add(1, 6'h23, 0, 1, DEC);  add(1, 6'h23, 0, 1, MA);
        add(1, 6'h23, 0, 0, MRD);  add(1, 6'h23, 0, 0, MRD);
        add(1, 6'h23, 0, 0, MRD);  add(1, 6'h23, 0, 1, MRD);
        add(1, 6'h23, 0, 1, MWB);
        // beq taken / not taken
        add(1, 6'h04, 1, 1, F1);   add(1, 6'h04, 1, 1, DEC);  add(1, 6'h04, 1, 1, BRZ1);
        add(1, 6'h04, 0, 1, F1);   add(1, 6'h04, 0, 1, DEC);  add(1, 6'h04, 0, 1, BRZ0);
        // j
        add(1, 6'h02, 0, 1, F1);   add(1, 6'h02, 0, 1, DEC);  add(1, 6'h02, 0, 1, JMP);
        // illegal opcode
        add(1, 6'h3F, 0, 1, F1);   add(1, 6'h3F, 0, 1, DILL);
        // addi
        add(1, 6'h08, 0, 1, F1);
`ifdef MAIN_CTRL_ADDI_EN
        add(1, 6'h08, 0, 1, DEC);  add(1, 6'h08, 0, 1, MA);   add(1, 6'h08, 0, 1, IWB);
`else
        add(1, 6'h08, 0, 1, DILL);
`endif
        // sw with one MEMWR stall
        add(1, 6'h2B, 0, 1, F1);   add(1, 6'h2B, 0, 1, DEC);  add(1, 6'h2B, 0, 1, MA);
        add(1, 6'h2B, 0, 0, MWR0); add(1, 6'h2B, 0, 1, MWR1);
        // sw with reset pulsed during MEMWR
        add(1, 6'h2B, 0, 1, F1);   add(1, 6'h2B, 0, 1, DEC);  add(1, 6'h2B, 0, 0, MA);
        add(0, 6'h2B, 0, 1, RST);
        add(1, 6'h02, 0, 1, F1);   add(1, 6'h02, 0, 1, DEC);  add(1, 6'h02, 0, 1, JMP);
        // lw with reset during MEMWB: no register write
        add(1, 6'h23, 0, 1, F1);   add(1, 6'h23, 0, 1, DEC);  add(1, 6'h23, 0, 1, MA);
        add(1, 6'h23, 0, 1, MRD);  add(0, 6'h23, 0, 1, RST);
        add(1, 6'h02, 0, 1, F1);   add(1, 6'h02, 0, 1, DEC);  add(1, 6'h02, 0, 1, JMP);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #2;
            rst_n = tbl[i].rst; Op = tbl[i].op; Zero = tbl[i].z; mem_ready = tbl[i].mr;
            #2;
            check($sformatf("vec%0d", i), actual(), tbl[i].exp);
        end

        // R-type with 4 FETCH stalls: instr_done expected on cycle 8
        lat = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk);
            #2;
            Op = 6'h00; Zero = 1'b0; mem_ready = (c > 4);
            #2;
            if (instr_done) begin
                lat = c;
                break;
            end
        end
        tests++;
        if (lat != 8) begin
            fails++;
            $display("FAIL stall_latency got=%0d expected=8 (0 = timeout)", lat);
        end

        // asynchronous reset between clock edges while in EXEC
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            Op = 6'h00; mem_ready = 1'b1;
        end
        #2;
        check("exec_state", actual(), EXE);
        #1 rst_n = 1'b0;
        #1 check("async_reset", actual(), RST);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #2 check("after_async_reset", actual(), F1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
